// File: rtl/ks_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

  // One prefix-tree node: group propagate and group generate.
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Register stages: one P/G generate stage plus one stage per group of
  // pipe_every prefix levels; the last group shares its stage with the sum.
  function automatic int ks_nstg(input int width, input int pipe_every);
    int lv;
    lv = clog2(width);
    return 1 + (lv + pipe_every - 1) / pipe_every;
  endfunction

endpackage

// File: rtl/ks_adder_pipe_if.sv
// Operand/result handshake bundle for ks_adder_pipe.
interface ks_adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/ks_prefix_row.sv
// One combinational Kogge-Stone prefix row: bit j absorbs bit j-DIST.
module ks_prefix_row
  import ks_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  pg_t [WIDTH-1:0] i_pg,
  output pg_t [WIDTH-1:0] o_pg
);

  // Black cells above DIST; lower bits pass through unchanged.
  always_comb begin
    // NOTE: assign every output a default first so no path leaves it unassigned (no latch).
    o_pg = i_pg;
    for (int j = DIST; j < WIDTH; j++) begin
      o_pg[j].g = i_pg[j].g | (i_pg[j].p & i_pg[j-DIST].g);
      o_pg[j].p = i_pg[j].p & i_pg[j-DIST].p;
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready at both ends.
// Stage 0 registers bitwise P/G, middle stages register prefix groups,
// last stage finishes the tree, folds in carry-in and registers the result.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PIPE_EVERY = 1
) (
  input logic         clk,
  input logic         rst_n,
  ks_adder_pipe_if.slave bus
);

  localparam int LV   = clog2(WIDTH);
  localparam int NSTG = ks_nstg(WIDTH, PIPE_EVERY);
  localparam int NREG = NSTG - 1;  // P/G register banks ahead of the result stage

  typedef pg_t [WIDTH-1:0] pgv_t;

  logic [NSTG-1:0]  r_v;
  logic [NSTG-1:0]  w_rdy;
  logic [NSTG-1:0]  w_load;

  pgv_t             r_pg   [NREG];
  logic [WIDTH-1:0] r_praw [NREG];   // bitwise a^b_eff, needed for the final XOR
  logic [NREG-1:0]  r_c0;            // effective carry-in, travels with its operands

  pgv_t             w_pg_gen;
  logic [WIDTH-1:0] w_b_eff;
  pgv_t             w_grp [NREG];    // value each P/G bank loads
  pgv_t             w_fin;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // Stage i may load when it is empty or every stage downstream can move.
  always_comb begin
    w_rdy  = '0;
    w_load = '0;
    for (int i = 0; i < NSTG; i++) begin
      w_rdy[i] = bus.out_ready | ~&(r_v | NSTG'((1 << i) - 1));
    end
    w_load[0] = w_rdy[0] & bus.in_valid;
    for (int i = 1; i < NSTG; i++) begin
      w_load[i] = w_rdy[i] & r_v[i-1];
    end
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = r_v[NSTG-1];
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

  // Valid bits advance wherever the stage is ready; bubbles fill in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
      if (w_rdy[0]) r_v[0] <= bus.in_valid;
      for (int i = 1; i < NSTG; i++) begin
        if (w_rdy[i]) r_v[i] <= r_v[i-1];
      end
    end
  end

  // Bitwise propagate/generate of the effective operands.
  always_comb begin
    w_b_eff = bus.sub ? ~bus.b : bus.b;
    for (int j = 0; j < WIDTH; j++) begin
      w_pg_gen[j].p = bus.a[j] ^ w_b_eff[j];
      w_pg_gen[j].g = bus.a[j] & w_b_eff[j];
    end
  end

  // Prefix levels, with a register bank in front of every PIPE_EVERY-th level.
  for (genvar k = 0; k < LV; k++) begin : g_lvl
    pgv_t w_in;
    pgv_t w_out;
    if (k % PIPE_EVERY == 0) begin : g_from_reg
      assign w_in = r_pg[k / PIPE_EVERY];
    end else begin : g_from_row
      assign w_in = g_lvl[k-1].w_out;
    end
    ks_prefix_row #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_row (
      .i_pg (w_in),
      .o_pg (w_out)
    );
  end

  // Bank 0 takes fresh P/G; bank s takes the output of its group's last level.
  for (genvar s = 0; s < NREG; s++) begin : g_grp
    if (s == 0) begin : g_gen
      assign w_grp[s] = w_pg_gen;
    end else begin : g_tap
      assign w_grp[s] = g_lvl[s*PIPE_EVERY-1].w_out;
    end
  end

  assign w_fin = g_lvl[LV-1].w_out;

  // Payload registers advance with their valid bit and hold while stalled.
  // NOTE: payload carries no reset; only valid bits and visible outputs need a known value.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NREG; s++) begin
      if (w_load[s]) r_pg[s] <= w_grp[s];
    end
    if (w_load[0]) begin
      r_praw[0] <= bus.a ^ w_b_eff;
      r_c0[0]   <= bus.cin ^ bus.sub;
    end
    for (int s = 1; s < NREG; s++) begin
      if (w_load[s]) begin
        r_praw[s] <= r_praw[s-1];
        r_c0[s]   <= r_c0[s-1];
      end
    end
  end

  // Carry into bit j+1 is the [j:0] group with carry-in as generate at bit -1.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = r_c0[NREG-1];
    for (int j = 0; j < WIDTH; j++) begin
      w_carry[j+1] = w_fin[j].g | (w_fin[j].p & r_c0[NREG-1]);
    end
    w_sum = r_praw[NREG-1] ^ w_carry[WIDTH-1:0];
  end

  // Result registers; signed overflow is carry into MSB differing from carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_load[NSTG-1]) begin
      r_sum  <= w_sum;
      r_cout <= w_carry[WIDTH];
      r_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed and randomised checks for ks_adder_pipe (8/1 and 13/2 builds).
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ks_adder_pipe_if #(.WIDTH(8))  bus8 ();
  ks_adder_pipe_if #(.WIDTH(13)) bus13 ();

  ks_adder_pipe #(.WIDTH(8), .PIPE_EVERY(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  ks_adder_pipe #(.WIDTH(13), .PIPE_EVERY(2)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus13)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
  } op8_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } res8_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  op8_t  q_op[$];
  res8_t q_res[$];
  int    acc_cyc[$];
  int    hold_viol;
  bit    inrdy_low;

  // Drive the 8-bit stream in q_op; collect accepts and results with cycle stamps.
  task automatic run_stream(input int stall_start, input int stall_len);
    int idx = 0;
    int c = 0;
    bit pv = 0;
    logic [7:0] ps;
    logic pc, po;
    res8_t r;
    acc_cyc.delete();
    q_res.delete();
    hold_viol = 0;
    inrdy_low = 0;
    ps = '0; pc = 0; po = 0;
    while (q_res.size() < q_op.size() && c < 200) begin
      @(negedge clk);
      bus8.out_ready = !(c >= stall_start && c < stall_start + stall_len);
      if (idx < q_op.size()) begin
        bus8.in_valid = 1'b1;
        bus8.a   = q_op[idx].a;
        bus8.b   = q_op[idx].b;
        bus8.cin = q_op[idx].cin;
        bus8.sub = q_op[idx].sub;
      end else begin
        bus8.in_valid = 1'b0;
      end
      #1;
      if (pv && (!bus8.out_valid || bus8.sum !== ps || bus8.cout !== pc || bus8.ovf !== po))
        hold_viol++;
      pv = bus8.out_valid && !bus8.out_ready;
      ps = bus8.sum; pc = bus8.cout; po = bus8.ovf;
      if (bus8.in_valid && !bus8.in_ready) inrdy_low = 1;
      if (bus8.in_valid && bus8.in_ready) begin
        acc_cyc.push_back(c);
        idx++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        r.sum = bus8.sum; r.cout = bus8.cout; r.ovf = bus8.ovf; r.cyc = c;
        q_res.push_back(r);
      end
      c++;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    if (q_res.size() < q_op.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL stream_timeout: got %0d results, expected %0d", q_res.size(), q_op.size());
    end
  endtask

  task automatic test_reset();
    bus8.in_valid = 0; bus8.out_ready = 1; bus8.a = 0; bus8.b = 0; bus8.cin = 0; bus8.sub = 0;
    bus13.in_valid = 0; bus13.out_ready = 1; bus13.a = 0; bus13.b = 0; bus13.cin = 0; bus13.sub = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus8.out_valid, bus8.cout, bus8.ovf} !== 3'b000 || bus8.sum !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b sum=%0d cout=%b ovf=%b, expected all 0",
               bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (bus8.in_ready !== 1'b1 || bus13.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b/%b, expected 1/1", bus8.in_ready, bus13.in_ready);
    end
  endtask

  task automatic test_single();
    q_op.delete();
    q_op.push_back('{a: 8'd2, b: 8'd5, cin: 1'b0, sub: 1'b0});
    run_stream(1000, 0);
    n_cmp++;
    if (q_res.size() != 1) begin
      n_bad++;
      $display("FAIL single_count: got %0d, expected 1", q_res.size());
    end else begin
      n_cmp++;
      if (q_res[0].sum !== 8'd7 || q_res[0].cout !== 1'b0 || q_res[0].ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL single_value: got sum=%0d cout=%b ovf=%b, expected 7/0/0",
                 q_res[0].sum, q_res[0].cout, q_res[0].ovf);
      end
      n_cmp++;
      if (q_res[0].cyc - acc_cyc[0] != 4) begin
        n_bad++;
        $display("FAIL single_latency: got %0d, expected 4", q_res[0].cyc - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea [5] = '{8'd1, 8'd20, 8'd75, 8'd128, 8'd200};
    logic [7:0] eb [5] = '{8'd1, 8'd20, 8'd75, 8'd128, 8'd20};
    logic       ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [5] = '{8'd2, 8'd41, 8'd151, 8'd0, 8'd220};
    logic       eco[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       eov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    q_op.delete();
    for (int i = 0; i < 5; i++) q_op.push_back('{a: ea[i], b: eb[i], cin: ec[i], sub: 1'b0});
    run_stream(1000, 0);
    n_cmp++;
    if (q_res.size() != 5) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d, expected 5", q_res.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (q_res[i].sum !== es[i] || q_res[i].cout !== eco[i] || q_res[i].ovf !== eov[i]) begin
          n_bad++;
          $display("FAIL b2b_value[%0d]: got sum=%0d cout=%b ovf=%b, expected %0d/%b/%b",
                   i, q_res[i].sum, q_res[i].cout, q_res[i].ovf, es[i], eco[i], eov[i]);
        end
        n_cmp++;
        if (q_res[i].cyc != q_res[0].cyc + i || acc_cyc[i] != acc_cyc[0] + i) begin
          n_bad++;
          $display("FAIL b2b_spacing[%0d]: got out cyc %0d acc cyc %0d, expected %0d/%0d",
                   i, q_res[i].cyc, acc_cyc[i], q_res[0].cyc + i, acc_cyc[0] + i);
        end
      end
      n_cmp++;
      if (q_res[0].cyc - acc_cyc[0] != 4) begin
        n_bad++;
        $display("FAIL b2b_latency: got %0d, expected 4", q_res[0].cyc - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_sub();
    q_op.delete();
    q_op.push_back('{a: 8'd5, b: 8'd7, cin: 1'b0, sub: 1'b1});
    q_op.push_back('{a: 8'd7, b: 8'd5, cin: 1'b1, sub: 1'b1});
    run_stream(1000, 0);
    n_cmp++;
    if (q_res.size() != 2) begin
      n_bad++;
      $display("FAIL sub_count: got %0d, expected 2", q_res.size());
    end else begin
      n_cmp++;
      if (q_res[0].sum !== 8'd254 || q_res[0].cout !== 1'b0 || q_res[0].ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL sub_5m7: got sum=%0d cout=%b ovf=%b, expected 254/0/0",
                 q_res[0].sum, q_res[0].cout, q_res[0].ovf);
      end
      n_cmp++;
      if (q_res[1].sum !== 8'd1 || q_res[1].cout !== 1'b1 || q_res[1].ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL sub_7m5m1: got sum=%0d cout=%b ovf=%b, expected 1/1/0",
                 q_res[1].sum, q_res[1].cout, q_res[1].ovf);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] beff;
    logic [8:0] full;
    logic       eovf;
    q_op.delete();
    for (int i = 0; i < 10; i++)
      q_op.push_back('{a: 8'(i * 23 + 7), b: 8'(i * 11), cin: 1'(i & 1), sub: (i == 3 || i == 7)});
    run_stream(4, 6);
    n_cmp++;
    if (inrdy_low !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_in_ready_drop: got %b, expected 1", inrdy_low);
    end
    n_cmp++;
    if (hold_viol != 0) begin
      n_bad++;
      $display("FAIL bp_hold_stable: got %0d changes, expected 0", hold_viol);
    end
    n_cmp++;
    if (q_res.size() != 10) begin
      n_bad++;
      $display("FAIL bp_count: got %0d, expected 10", q_res.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        beff = q_op[i].sub ? ~q_op[i].b : q_op[i].b;
        full = {1'b0, q_op[i].a} + {1'b0, beff} + {8'd0, q_op[i].cin ^ q_op[i].sub};
        eovf = (q_op[i].a[7] == beff[7]) && (full[7] != q_op[i].a[7]);
        n_cmp++;
        if ({q_res[i].ovf, q_res[i].cout, q_res[i].sum} !== {eovf, full}) begin
          n_bad++;
          $display("FAIL bp_value[%0d]: got sum=%0d cout=%b ovf=%b, expected %0d/%b/%b",
                   i, q_res[i].sum, q_res[i].cout, q_res[i].ovf, full[7:0], full[8], eovf);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus8.out_ready = 1'b1;
      bus8.in_valid  = 1'b1;
      bus8.a = 8'(10 * (i + 1)); bus8.b = 8'(i + 1); bus8.cin = 0; bus8.sub = 0;
    end
    @(negedge clk);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (bus8.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_prefill: got out_valid=%b, expected 1", bus8.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus8.out_valid !== 1'b0 || bus8.sum !== 8'd0 || bus8.cout !== 1'b0 || bus8.ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async: got v=%b sum=%0d cout=%b ovf=%b, expected 0/0/0/0",
               bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (bus8.out_valid) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_bad++;
      $display("FAIL midrst_stale: got %0d stale results, expected 0", stale);
    end
    q_op.delete();
    q_op.push_back('{a: 8'd3, b: 8'd4, cin: 1'b0, sub: 1'b0});
    run_stream(1000, 0);
    n_cmp++;
    if (q_res.size() != 1) begin
      n_bad++;
      $display("FAIL midrst_count: got %0d, expected 1", q_res.size());
    end else begin
      n_cmp++;
      if (q_res[0].sum !== 8'd7 || q_res[0].cyc - acc_cyc[0] != 4) begin
        n_bad++;
        $display("FAIL midrst_after: got sum=%0d latency=%0d, expected 7/4",
                 q_res[0].sum, q_res[0].cyc - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_w13();
    logic [14:0] exp_q[$];
    logic [14:0] e;
    logic [12:0] beff;
    logic [13:0] full;
    logic        eovf;
    int  sent = 0, rcvd = 0, cyc = 0, lat = 0;
    bit  seen = 0, accepted = 0;
    // Directed: 100 + 200 + 1 = 301, three-stage latency.
    @(negedge clk);
    bus13.out_ready = 1'b1;
    bus13.in_valid = 1'b1; bus13.a = 13'd100; bus13.b = 13'd200; bus13.cin = 1'b1; bus13.sub = 1'b0;
    @(posedge clk); #1;
    bus13.in_valid = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (bus13.out_valid) begin
        seen = 1;
        lat = i;
      end
    end
    n_cmp++;
    if (!seen || lat != 3 || bus13.sum !== 13'd301 || bus13.cout !== 1'b0) begin
      n_bad++;
      $display("FAIL w13_directed: got seen=%b lat=%0d sum=%0d cout=%b, expected 1/3/301/0",
               seen, lat, bus13.sum, bus13.cout);
    end
    @(negedge clk);
    // Randomised traffic with random stalls on both sides.
    while (rcvd < 1000 && cyc < 20000) begin
      @(negedge clk);
      if (accepted) begin
        bus13.in_valid = 1'b0;
        accepted = 0;
      end
      bus13.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus13.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        bus13.a   = 13'($urandom);
        bus13.b   = 13'($urandom);
        bus13.cin = 1'($urandom);
        bus13.sub = 1'($urandom);
        bus13.in_valid = 1'b1;
      end
      #1;
      if (bus13.out_valid && bus13.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL w13_unexpected: got sum=%0d with no operation outstanding", bus13.sum);
        end else begin
          e = exp_q.pop_front();
          if ({bus13.ovf, bus13.cout, bus13.sum} !== e) begin
            n_bad++;
            $display("FAIL w13_result[%0d]: got ovf=%b cout=%b sum=%0d, expected %b/%b/%0d",
                     rcvd, bus13.ovf, bus13.cout, bus13.sum, e[14], e[13], e[12:0]);
          end
        end
        rcvd++;
      end
      if (bus13.in_valid && bus13.in_ready) begin
        beff = bus13.sub ? ~bus13.b : bus13.b;
        full = {1'b0, bus13.a} + {1'b0, beff} + {13'd0, bus13.cin ^ bus13.sub};
        eovf = (bus13.a[12] == beff[12]) && (full[12] != bus13.a[12]);
        exp_q.push_back({eovf, full});
        sent++;
        accepted = 1;
      end
      cyc++;
    end
    bus13.in_valid  = 1'b0;
    bus13.out_ready = 1'b1;
    n_cmp++;
    if (rcvd != 1000 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL w13_complete: got %0d results, %0d outstanding, expected 1000/0",
               rcvd, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sub();
    test_backpressure();
    test_reset_midflight();
    test_w13();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
